// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl -- multi-cycle MIPS control FSM.
//
// Decodes Op/Funct of the instruction held in IR and sequences it over 3-5
// cycles, driving ALU operation, datapath mux selects and the PC/IR/RF/DM
// write enables. Also keeps a count of retired instructions.
//
// Ports:
//   clk, rstn            rising-edge clock, asynchronous active-low reset
//   Op, Funct            IR[31:26] / IR[5:0]
//   Zero                 ALU zero flag (used only to resolve branches)
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables
//   IorD, RegDst, WDSel, ALUSrcA, ALUSrcB, EXTOp, PCSource  mux selects
//   ALUOp                ALU operation code (ALU_* below)
//   instr_done           pulse on the last cycle of each instruction
//   instret              retired-instruction count (wraps)
//   illegal              sticky illegal-opcode flag
//
// Build option: define ILLEGAL_TRAP_EN to send unknown opcodes to a TRAP
// state that sets `illegal` and holds until reset. Without it an unknown
// opcode is a 2-cycle NOP and `illegal` is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_FETCH   | read IMEM[PC] into IR, PC <= PC+4
// S_DECODE  | decode Op, precompute branch target into ALUOut
// S_EXE_R   | R-type ALU operation
// S_EXE_I   | I-type ALU operation with immediate
// S_WB_R    | write ALUOut to rd
// S_WB_I    | write ALUOut to rt
// S_MEM_ADR | compute load/store address
// S_MEM_RD  | read data memory into MDR
// S_MEM_WB  | write MDR to rt
// S_MEM_WR  | write B to data memory
// S_BRANCH  | compare A/B, take branch on condition
// S_JUMP    | load jump target, optional link to $31
// S_TRAP    | illegal opcode, frozen until reset (ILLEGAL_TRAP_EN)
module mccpu_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       WDSel,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             EXTOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUOp,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_LUI  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_WB_R, S_WB_I,
        S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;

    logic       pcw_d, irw_d, iord_d, memw_d, regw_d, ext_d, done_d;
    logic [1:0] regdst_d, wdsel_d, srca_d, srcb_d, pcsrc_d;
    logic [3:0] aluop_d;

    always_comb begin
        state_d  = state_q;
        pcw_d    = 1'b0;
        irw_d    = 1'b0;
        iord_d   = 1'b0;
        memw_d   = 1'b0;
        regw_d   = 1'b0;
        ext_d    = 1'b0;
        done_d   = 1'b0;
        regdst_d = 2'b00;
        wdsel_d  = 2'b00;
        srca_d   = 2'b00;
        srcb_d   = 2'b00;
        pcsrc_d  = 2'b00;
        aluop_d  = ALU_NOP;
        case (state_q)
            S_FETCH: begin
                irw_d   = 1'b1;
                pcw_d   = 1'b1;
                srcb_d  = 2'b01;
                aluop_d = ALU_ADD;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively for every opcode.
                srcb_d  = 2'b11;
                ext_d   = 1'b1;
                aluop_d = ALU_ADD;
                case (Op)
                    OP_RTYPE:                    state_d = S_EXE_R;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_SLTIU, OP_LUI:   state_d = S_EXE_I;
                    OP_LW, OP_SW:                state_d = S_MEM_ADR;
                    OP_BEQ, OP_BNE:              state_d = S_BRANCH;
                    OP_J, OP_JAL:                state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                     state_d = S_TRAP;
`else
                    default:                     state_d = S_FETCH;
`endif
                endcase
            end
            S_EXE_R: begin
                srca_d  = 2'b01;
                state_d = S_WB_R;
                case (Funct)
                    FN_ADD, FN_ADDU: aluop_d = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop_d = ALU_SUB;
                    FN_AND:          aluop_d = ALU_AND;
                    FN_OR:           aluop_d = ALU_OR;
                    FN_NOR:          aluop_d = ALU_NOR;
                    FN_SLT:          aluop_d = ALU_SLT;
                    FN_SLTU:         aluop_d = ALU_SLTU;
                    // Constant shifts take the amount from the shamt field.
                    FN_SLL: begin srca_d = 2'b10; aluop_d = ALU_SLL; end
                    FN_SRL: begin srca_d = 2'b10; aluop_d = ALU_SRL; end
                    FN_SLLV:         aluop_d = ALU_SLL;
                    FN_SRLV:         aluop_d = ALU_SRL;
                    default:         aluop_d = ALU_NOP;
                endcase
            end
            S_EXE_I: begin
                srca_d  = 2'b01;
                srcb_d  = 2'b10;
                state_d = S_WB_I;
                case (Op)
                    OP_ADDI:  begin ext_d = 1'b1; aluop_d = ALU_ADD;  end
                    OP_SLTI:  begin ext_d = 1'b1; aluop_d = ALU_SLT;  end
                    OP_SLTIU: begin ext_d = 1'b1; aluop_d = ALU_SLTU; end
                    OP_ANDI:  aluop_d = ALU_AND;
                    OP_ORI:   aluop_d = ALU_OR;
                    OP_LUI:   aluop_d = ALU_LUI;
                    default:  aluop_d = ALU_NOP;
                endcase
            end
            S_WB_R: begin
                regw_d   = 1'b1;
                regdst_d = 2'b01;
                done_d   = 1'b1;
                state_d  = S_FETCH;
            end
            S_WB_I: begin
                regw_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADR: begin
                srca_d  = 2'b01;
                srcb_d  = 2'b10;
                ext_d   = 1'b1;
                aluop_d = ALU_ADD;
                state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord_d  = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                regw_d  = 1'b1;
                wdsel_d = 2'b01;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                iord_d  = 1'b1;
                memw_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                srca_d  = 2'b01;
                aluop_d = ALU_SUB;
                pcsrc_d = 2'b01;
                pcw_d   = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_d = 2'b10;
                pcw_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
                // PC already holds PC+4 from FETCH, so it is the link value.
                if (Op == OP_JAL) begin
                    regw_d   = 1'b1;
                    regdst_d = 2'b10;
                    wdsel_d  = 2'b10;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (done_d)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            illegal_q <= 1'b0;
        else if (state_d == S_TRAP)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Reset gates every output so an abandoned instruction cannot write.
    assign PCWrite    = rstn & pcw_d;
    assign IRWrite    = rstn & irw_d;
    assign IorD       = rstn & iord_d;
    assign MemWrite   = rstn & memw_d;
    assign RegWrite   = rstn & regw_d;
    assign EXTOp      = rstn & ext_d;
    assign instr_done = rstn & done_d;
    assign RegDst     = rstn ? regdst_d : 2'b00;
    assign WDSel      = rstn ? wdsel_d  : 2'b00;
    assign ALUSrcA    = rstn ? srca_d   : 2'b00;
    assign ALUSrcB    = rstn ? srcb_d   : 2'b00;
    assign PCSource   = rstn ? pcsrc_d  : 2'b00;
    assign ALUOp      = rstn ? aluop_d  : 4'd0;
    assign instret    = instret_q;

endmodule

// File: tb/tb_mccpu_ctrl.sv
module tb_mccpu_ctrl;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

    // ALU operation codes
    localparam logic [3:0] A_NOP = 0, A_ADD = 1, A_SUB = 2, A_AND = 3, A_OR = 4, A_SLT = 5;
    localparam logic [3:0] A_SLTU = 6, A_NOR = 7, A_LUI = 8, A_SLL = 9, A_SRL = 10;

    typedef struct packed {
        logic       pcw, irw, iord, memw, regw;
        logic [1:0] regdst, wdsel, srca, srcb;
        logic       ext;
        logic [1:0] pcsrc;
        logic [3:0] aluop;
        logic       done;
    } ctrl_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic [5:0]       Op, Funct;
    logic             Zero;
    logic             PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, instr_done, illegal;
    logic [1:0]       RegDst, WDSel, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0]       ALUOp;
    logic [CNT_W-1:0] instret;

    mccpu_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .PCSource(PCSource), .ALUOp(ALUOp),
        .instr_done(instr_done), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int unsigned exp_instret;
    logic        exp_illegal;
    ctrl_t       cap [0:4];

    logic [5:0] ops   [0:11] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                                 OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW};
    logic [5:0] fns   [0:12] = '{6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b100000,
                                 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                 6'b100111, 6'b101010, 6'b101011};
    logic [5:0] bads  [0:2]  = '{6'b111111, 6'b010000, 6'b110001};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t actual();
        ctrl_t a;
        a = '{PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
              ALUSrcA, ALUSrcB, EXTOp, PCSource, ALUOp, instr_done};
        return a;
    endfunction

    // Cycles an instruction takes from FETCH through its last cycle.
    function automatic int lat(input logic [5:0] op);
        case (op)
            OP_LW:                         return 5;
            OP_R, OP_SW, OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI:       return 4;
            OP_BEQ, OP_BNE, OP_J, OP_JAL:  return 3;
            default:                       return 2;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001: return A_ADD;
            6'b100010, 6'b100011: return A_SUB;
            6'b100100:            return A_AND;
            6'b100101:            return A_OR;
            6'b100111:            return A_NOR;
            6'b101010:            return A_SLT;
            6'b101011:            return A_SLTU;
            6'b000000, 6'b000100: return A_SLL;
            6'b000010, 6'b000110: return A_SRL;
            default:              return A_NOP;
        endcase
    endfunction

    // Expected controls for cycle `step` of an instruction (0 = fetch).
    function automatic ctrl_t model(input logic [5:0] op, input logic [5:0] fn,
                                    input int step, input logic z);
        ctrl_t c;
        c = '0;
        if (step == 0) begin
            c.pcw = 1; c.irw = 1; c.srcb = 2'b01; c.aluop = A_ADD;
        end else if (step == 1) begin
            c.srcb = 2'b11; c.ext = 1; c.aluop = A_ADD;
        end else if (op == OP_R) begin
            if (step == 2) begin
                c.srca  = (fn == 6'b000000 || fn == 6'b000010) ? 2'b10 : 2'b01;
                c.aluop = r_alu(fn);
            end else begin
                c.regw = 1; c.regdst = 2'b01; c.done = 1;
            end
        end else if (op == OP_LW || op == OP_SW) begin
            if (step == 2) begin
                c.srca = 2'b01; c.srcb = 2'b10; c.ext = 1; c.aluop = A_ADD;
            end else if (op == OP_SW) begin
                c.iord = 1; c.memw = 1; c.done = 1;
            end else if (step == 3) begin
                c.iord = 1;
            end else begin
                c.regw = 1; c.wdsel = 2'b01; c.done = 1;
            end
        end else if (op == OP_BEQ || op == OP_BNE) begin
            c.srca = 2'b01; c.aluop = A_SUB; c.pcsrc = 2'b01; c.done = 1;
            c.pcw  = (op == OP_BEQ) ? z : !z;
        end else if (op == OP_J || op == OP_JAL) begin
            c.pcsrc = 2'b10; c.pcw = 1; c.done = 1;
            if (op == OP_JAL) begin
                c.regw = 1; c.regdst = 2'b10; c.wdsel = 2'b10;
            end
        end else begin
            // I-type ALU
            if (step == 2) begin
                c.srca = 2'b01; c.srcb = 2'b10;
                c.ext  = (op == OP_ADDI || op == OP_SLTI || op == OP_SLTIU);
                case (op)
                    OP_ADDI:  c.aluop = A_ADD;
                    OP_SLTI:  c.aluop = A_SLT;
                    OP_SLTIU: c.aluop = A_SLTU;
                    OP_ANDI:  c.aluop = A_AND;
                    OP_ORI:   c.aluop = A_OR;
                    default:  c.aluop = A_LUI;
                endcase
            end else begin
                c.regw = 1; c.done = 1;
            end
        end
        return c;
    endfunction

    // zmode: 0/1 = hold Zero at that value, 2 = random each cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        ctrl_t e;
        ctrl_t a;
        int    n;
        n = lat(op);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            if (s == 0) begin
                Op = op;
                Funct = fn;
            end
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            e = model(op, fn, s, Zero);
            a = actual();
            cap[s] = a;
            chk($sformatf("ctrl op=%b fn=%b step%0d", op, fn, s), 64'(a), 64'(e));
            chk("instret", 64'(instret), 64'(exp_instret));
            chk("illegal", 64'(illegal), 64'(exp_illegal));
            if (e.done) exp_instret++;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        rstn = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;
        exp_instret = 0; exp_illegal = 1'b0;

        repeat (2) begin
            @(negedge clk);
            Op = 6'($urandom);
            #1;
            chk("reset_ctrl", 64'(actual()), 64'd0);
            chk("reset_instret", 64'(instret), 64'd0);
            chk("reset_illegal", 64'(illegal), 64'd0);
        end
        @(posedge clk); #2 rstn = 1'b1;

        // add
        run_instr(OP_R, 6'b100000, 2);
        chk("fetch_irwrite", 64'(cap[0].irw), 64'd1);
        chk("fetch_pcwrite", 64'(cap[0].pcw), 64'd1);
        chk("fetch_aluop", 64'(cap[0].aluop), 64'd1);
        chk("fetch_alusrcb", 64'(cap[0].srcb), 64'd1);
        chk("add_exe_aluop", 64'(cap[2].aluop), 64'd1);
        chk("add_wb_regwrite", 64'(cap[3].regw), 64'd1);
        chk("add_wb_regdst", 64'(cap[3].regdst), 64'd1);
        cnt = 0;
        for (int s = 0; s < 4; s++) cnt += int'(cap[s].done);
        chk("add_done_pulses", 64'(cnt), 64'd1);
        @(posedge clk); #1;
        chk("add_instret", 64'(instret), 64'd1);

        // lw / sw
        run_instr(OP_LW, 6'($urandom), 2);
        chk("lw_memrd_iord", 64'(cap[3].iord), 64'd1);
        chk("lw_memwb_regwrite", 64'(cap[4].regw), 64'd1);
        chk("lw_memwb_wdsel", 64'(cap[4].wdsel), 64'd1);
        chk("lw_memwb_regdst", 64'(cap[4].regdst), 64'd0);
        run_instr(OP_SW, 6'($urandom), 2);
        cnt = 0;
        for (int s = 0; s < 4; s++) cnt += int'(cap[s].memw);
        chk("sw_memwrite_cycles", 64'(cnt), 64'd1);

        // branches
        run_instr(OP_BEQ, 6'($urandom), 1);
        chk("beq_z1_pcwrite", 64'(cap[2].pcw), 64'd1);
        chk("beq_z1_pcsource", 64'(cap[2].pcsrc), 64'd1);
        run_instr(OP_BEQ, 6'($urandom), 0);
        chk("beq_z0_pcwrite", 64'(cap[2].pcw), 64'd0);
        run_instr(OP_BNE, 6'($urandom), 1);
        chk("bne_z1_pcwrite", 64'(cap[2].pcw), 64'd0);
        run_instr(OP_BNE, 6'($urandom), 0);
        chk("bne_z0_pcwrite", 64'(cap[2].pcw), 64'd1);

        // jal, sll
        run_instr(OP_JAL, 6'($urandom), 2);
        chk("jal_pcwrite", 64'(cap[2].pcw), 64'd1);
        chk("jal_pcsource", 64'(cap[2].pcsrc), 64'd2);
        chk("jal_regwrite", 64'(cap[2].regw), 64'd1);
        chk("jal_regdst", 64'(cap[2].regdst), 64'd2);
        chk("jal_wdsel", 64'(cap[2].wdsel), 64'd2);
        run_instr(OP_R, 6'b000000, 2);
        chk("sll_alusrca", 64'(cap[2].srca), 64'd2);
        chk("sll_aluop", 64'(cap[2].aluop), 64'd9);

`ifndef ILLEGAL_TRAP_EN
        run_instr(OP_BAD, 6'($urandom), 2);
        run_instr(OP_ADDI, 6'($urandom), 2);
        chk("after_illegal_fetch", 64'(cap[0].irw), 64'd1);
`endif

        // random instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = OP_SW;
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 11) == 0) op = bads[$urandom_range(0, 2)];
`endif
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
            run_instr(op, fn, 2);
        end

        // reset during MEM_WR
        run_instr(OP_SW, 6'($urandom), 2);
        chk("sw_memwr_before_reset", 64'(cap[3].memw), 64'd1);
        #2 rstn = 1'b0;
        #1;
        exp_instret = 0;
        chk("reset_memwrite", 64'(MemWrite), 64'd0);
        chk("reset_mid_ctrl", 64'(actual()), 64'd0);
        chk("reset_mid_instret", 64'(instret), 64'd0);
        @(posedge clk); #2 rstn = 1'b1;
        run_instr(OP_R, 6'b100100, 2);
        chk("restart_fetch", 64'(cap[0].irw), 64'd1);

`ifdef ILLEGAL_TRAP_EN
        run_instr(OP_BAD, 6'($urandom), 2);
        exp_illegal = 1'b1;
        repeat (3) begin
            @(negedge clk);
            Op = OP_R;
            Zero = 1'($urandom_range(0, 1));
            #1;
            chk("trap_ctrl", 64'(actual()), 64'd0);
            chk("trap_illegal", 64'(illegal), 64'd1);
            chk("trap_instret", 64'(instret), 64'(exp_instret));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
